// File: rtl/us_sensor_scheduler.sv
// us_sensor_scheduler: round-robin HC-SR04 scheduler sharing one echo timer
// and distance engine. Each sensor gets a fixed-length slot: trigger pulse,
// echo timing, millimetre conversion, per-sensor distance and obstacle flag.
// Optional build macro US_SCHED_FILTER_EN: obstacle needs two consecutive
// below-threshold readings before it rises.
module us_sensor_scheduler #(
  parameter int NUM_SENSORS = 3,
  parameter int TRIG_CYCLES = 500,
  parameter int SLOT_CYCLES = 600000,
  parameter int OBST_MM     = 70
) (
  input  logic                     clk_50M,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_SENSORS-1:0]   echo_rx,
  output logic [NUM_SENSORS-1:0]   trig,
  output logic [16*NUM_SENSORS-1:0] dist_mm,
  output logic [NUM_SENSORS-1:0]   obstacle,
  output logic                     valid,
  output logic [2:0]               sensor_id,
  output logic                     busy
);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, GAP} state_t;

  state_t                 state;
  logic [NUM_SENSORS-1:0] echo_s1, echo_s2, echo_s3;
  logic [19:0]            slot_cnt, echo_cnt;
  logic [2:0]             cur, nxt_cur;
  logic [NUM_SENSORS-1:0] cur_onehot, nxt_onehot;
  logic                   echo_now, echo_was, rise, fall;
  logic                   slot_end, trig_done;
  logic                   wr_meas, wr_tout, advance;
  logic [24:0]            prod;
  logic [15:0]            dist_calc;
  logic                   below;
`ifdef US_SCHED_FILTER_EN
  logic [NUM_SENSORS-1:0] below_prev;
`endif

  // Two-flop echo synchroniser plus one extra stage for edge detection
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      echo_s1 <= '0;
      echo_s2 <= '0;
      echo_s3 <= '0;
    end else begin
      echo_s1 <= echo_rx;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
    end
  end

  // Current-sensor selection, edge detection, slot timing and distance maths
  always_comb begin
    echo_now   = 1'b0;
    echo_was   = 1'b0;
    cur_onehot = '0;
    nxt_onehot = '0;
    nxt_cur    = (cur == 3'(NUM_SENSORS - 1)) ? 3'd0 : cur + 3'd1;
    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
      if (cur == 3'(i)) begin
        echo_now      = echo_s2[i];
        echo_was      = echo_s3[i];
        cur_onehot[i] = 1'b1;
      end
      if (nxt_cur == 3'(i)) nxt_onehot[i] = 1'b1;
    end
    rise      = echo_now & ~echo_was;
    fall      = ~echo_now & echo_was;
    slot_end  = (slot_cnt == 20'(SLOT_CYCLES - 1));
    trig_done = (slot_cnt == 20'(TRIG_CYCLES - 1));
    // A falling edge on the slot's last cycle counts as a measurement
    wr_meas   = (state == MEASURE) && fall;
    wr_tout   = slot_end && ((state == WAIT_ECHO) || ((state == MEASURE) && !fall));
    advance   = slot_end && ((state == WAIT_ECHO) || (state == MEASURE) || (state == GAP));
    prod      = 25'(echo_cnt) * 25'd17;
    dist_calc = 16'(prod / 25'd5000);
    below     = (dist_calc < 16'(OBST_MM));
  end

  // Slot state machine: trigger, wait for echo, measure, idle out the slot
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      slot_cnt <= '0;
      echo_cnt <= '0;
      cur      <= '0;
      trig     <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          slot_cnt <= '0;
          echo_cnt <= '0;
          if (enable) begin
            state <= TRIG;
            trig  <= cur_onehot;
            busy  <= 1'b1;
          end
        end
        TRIG: begin
          slot_cnt <= slot_cnt + 20'd1;
          if (trig_done) begin
            trig  <= '0;
            state <= WAIT_ECHO;
          end
        end
        WAIT_ECHO: begin
          slot_cnt <= slot_cnt + 20'd1;
          if (rise) begin
            echo_cnt <= 20'd1;
            state    <= MEASURE;
          end
        end
        MEASURE: begin
          slot_cnt <= slot_cnt + 20'd1;
          if (echo_now) echo_cnt <= echo_cnt + 20'd1;
          if (fall) state <= GAP;
        end
        GAP: slot_cnt <= slot_cnt + 20'd1;
        default: state <= IDLE;
      endcase
      if (advance) begin
        cur      <= nxt_cur;
        slot_cnt <= '0;
        echo_cnt <= '0;
        if (enable) begin
          state <= TRIG;
          trig  <= nxt_onehot;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

  // Result registers: write distance/obstacle for the current sensor
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      dist_mm    <= '0;
      obstacle   <= '0;
      valid      <= 1'b0;
      sensor_id  <= '0;
`ifdef US_SCHED_FILTER_EN
      below_prev <= '0;
`endif
    end else begin
      valid <= wr_meas | wr_tout;
      if (wr_meas | wr_tout) sensor_id <= cur;
      for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
        if (cur_onehot[i]) begin
          if (wr_meas) begin
            dist_mm[16*i +: 16] <= dist_calc;
`ifdef US_SCHED_FILTER_EN
            obstacle[i]   <= below & below_prev[i];
            below_prev[i] <= below;
`else
            obstacle[i]   <= below;
`endif
          end else if (wr_tout) begin
            dist_mm[16*i +: 16] <= 16'hFFFF;
            obstacle[i]         <= 1'b0;
`ifdef US_SCHED_FILTER_EN
            below_prev[i]       <= 1'b0;
`endif
          end
        end
      end
    end
  end

endmodule

// File: doc/us_sensor_scheduler.md
# us_sensor_scheduler

Round-robin scheduler that shares one echo-timing and distance engine between several HC-SR04 ultrasonic sensors on the MazeSolver bot. It fires one sensor per fixed-length slot so that neighbouring sensors cannot cross-talk, and times that sensor's echo pulse. It converts each echo to millimetres, then publishes a per-sensor distance and obstacle flag. It sits between the sensor pins and the navigation logic.

## Interface
- `NUM_SENSORS`, 3: number of sensors sharing the engine (1–8).
- `TRIG_CYCLES`, 500: trigger pulse width in clk_50M cycles (10 µs).
- `SLOT_CYCLES`, 600000: slot length from trigger start to next sensor (12 ms).
- `OBST_MM`, 70: obstacle threshold in mm; obstacle is asserted when the distance is strictly less than this value.

- `clk_50M`  in  1  50 MHz clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run the scheduler; when low, the block parks in IDLE once the current slot finishes.
- `echo_rx`  in  NUM_SENSORS  echo pins; bit i belongs to sensor i.
- `trig`  out  NUM_SENSORS  trigger pins; bit i belongs to sensor i.
- `dist_mm`  out  16*NUM_SENSORS  latest distance per sensor; sensor i occupies bits [16i+15:16i].
- `obstacle`  out  NUM_SENSORS  latest obstacle flag per sensor.
- `valid`  out  1  one-cycle pulse when a result is written.
- `sensor_id`  out  3  sensor whose result is being written; meaningful only while `valid` is high.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Each `echo_rx` bit passes through a 2-flop synchroniser. All echo logic uses the synchronised copy.
- Internal state:
  - a slot counter, 20 bits;
  - an echo counter, 20 bits;
  - the current sensor index `cur`.
- State machine:
  - **IDLE**: counters cleared. If `enable` is high, go to TRIG next cycle; `cur` keeps its value.
  - **TRIG**: `trig[cur]` is high for exactly TRIG_CYCLES cycles, then go to WAIT_ECHO. Echo activity during TRIG is ignored.
  - **WAIT_ECHO**: a rising edge of `echo[cur]` goes to MEASURE. A high level already present on entry is not a rising edge.
  - **MEASURE**: the echo counter increments every cycle that `echo[cur]` is high.
    - A falling edge writes the result and goes to GAP.
  - **GAP**: hold until the slot ends.
    - Slot end: `cur` advances to (`cur`+1) mod NUM_SENSORS.
    - Next state is TRIG if `enable` is high, otherwise IDLE.
- Distance: `dist = (echo_count * 17) / 5000`, computed with a 25-bit product and truncating division. The result fits in 16 bits (maximum 2040).
- Obstacle flag: `obstacle[cur] = (dist < OBST_MM)`.
- Timeout: if the slot ends while in WAIT_ECHO or MEASURE:
  - write `dist_mm[cur] = 16'hFFFF` and `obstacle[cur] = 0`;
  - pulse `valid`;
  - then advance as for a normal slot end.
- Only `trig[cur]` is ever driven high; the other trigger bits stay 0.
- Results for the other sensors hold their values until that sensor's own slot writes a new result.

## Timing
- Reset values:
  - `trig` = 0, `dist_mm` = 0, `obstacle` = 0, `valid` = 0, `sensor_id` = 0, `busy` = 0;
  - state = IDLE, `cur` = 0, both counters = 0.
- Reset asserted mid-slot: all outputs go to their reset values immediately (asynchronously), including dropping any active trigger.
- The slot counter starts at 0 on the first TRIG cycle. The slot ends on the cycle the counter reaches SLOT_CYCLES−1. Each slot is exactly SLOT_CYCLES cycles from trigger rise to the next trigger rise.
- Echo-to-result latency: `dist_mm`, `obstacle`, `valid` and `sensor_id` update together, 3 cycles after the pin falls (2 synchroniser cycles plus 1 register cycle).
  - The synchroniser delay affects both edges equally, so echo count = pin-high cycles.
- `valid` is never asserted twice in one slot.
- `enable` falling mid-slot: the current slot completes normally, including its result; the block then goes to IDLE.
- `enable` rising again: TRIG starts on the cycle after IDLE samples `enable` high, for the retained `cur`.
- Echo falling edge and slot end on the same cycle: the measured result wins, not the timeout.

## Configuration
- `US_SCHED_FILTER_EN` defined:
  - `obstacle[i]` rises only after 2 consecutive non-timeout readings of sensor i that are below OBST_MM;
  - it clears on the first reading at or above OBST_MM, or on a timeout;
  - `dist_mm` is still updated with every reading.
- `US_SCHED_FILTER_EN` undefined: `obstacle[i]` follows each individual reading directly.

## Test plan
- Reset release, `enable`=1, NUM_SENSORS=3, no echoes:
  - `trig[0]` high for 500 cycles;
  - slot 0 times out with `valid`, `sensor_id`=0, `dist_mm[0]`=FFFF;
  - `trig[1]` rises exactly 600000 cycles after `trig[0]` rose.
- Sensor 0 echo high for 20588 cycles -> `dist_mm[0]`=69, `obstacle[0]`=1. Echo high for 20589 cycles -> 70, `obstacle`=0 (filter disabled).
- Echo held high from TRIG start through slot end -> timeout result FFFF, `obstacle`=0, and no rising edge is counted.
- Deassert `enable` mid-MEASURE -> the result is written, `busy` drops at slot end, and `trig` stays 0 afterwards. Reassert -> the next sensor is triggered.
- Assert `reset` while `trig[1]` is high -> `trig`, `valid`, `busy`, `dist_mm` and `obstacle` all go to 0 in the same cycle. After release, the sequence restarts at sensor 0.
- With `US_SCHED_FILTER_EN` defined, sensor 2 readings 40, 40, 100 mm -> `obstacle[2]` goes 0, 1, 0.
